fft_bitrev_reorder: RTL and testbench

// - Output reorder buffer directly downstream of the radix-2 butterfly stage.
// - Captures the butterfly's stream in arrival order and replays each N-sample frame in bit-reversed index order.
// - Ping-pong banks let frame k+1 be written while frame k is read.
// - Input has no backpressure, because the butterfly cannot stall. The output uses a valid/ready handshake.

---
 rtl/fft_bitrev_reorder.sv | 143 ++++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: captures N-sample frames in arrival order and replays them bit-reversed.
// Optional macro FFT_REORDER_BYPASS_EN adds a per-frame `bypass` input selecting natural-order readout.
module fft_bitrev_reorder #(
  parameter int DATA_WIDTH = 32,
  parameter int LOG2_N     = 6
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef FFT_REORDER_BYPASS_EN
  input  logic                  bypass,
`endif
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  ovf
);

  localparam int N = 1 << LOG2_N;

  typedef logic [LOG2_N-1:0] idx_t;
  typedef enum logic {IDLE, READ} state_t;

  logic [DATA_WIDTH-1:0] mem [2*N];
  logic [1:0]            full;
  logic [1:0]            full_set;
  logic [1:0]            full_clr;
  logic                  wr_bank;
  logic                  rd_bank;
  idx_t                  wr_cnt;
  idx_t                  rd_cnt;
  idx_t                  wr_addr;
  idx_t                  rd_addr;
  logic                  wr_accept;
  logic                  wr_last;
  logic                  rd_load;
  logic                  rd_done;
  state_t                state;
  state_t                state_nxt;
`ifdef FFT_REORDER_BYPASS_EN
  logic                  bypass_q;
`endif

  function automatic idx_t bitrev(input idx_t k);
    idx_t r;
    r = '0;
    for (int i = 0; i < LOG2_N; i++) r[LOG2_N-1-i] = k[i];
    return r;
  endfunction

  // A bank is only written while not full and only read while full, so set and clear never hit the same bank.
  always_comb begin
    wr_accept = in_valid && !full[wr_bank];
    wr_addr   = in_sof ? '0 : wr_cnt;
    wr_last   = wr_accept && (wr_addr == idx_t'(N-1));
    full_set  = 2'b00;
    if (wr_last) full_set[wr_bank] = 1'b1;
    full_clr  = 2'b00;
    if (rd_done) full_clr[rd_bank] = 1'b1;
`ifdef FFT_REORDER_BYPASS_EN
    rd_addr   = bypass_q ? rd_cnt : bitrev(rd_cnt);
`else
    rd_addr   = bitrev(rd_cnt);
`endif
  end

  always_ff @(posedge clk) begin
    if (wr_accept) mem[{wr_bank, wr_addr}] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_load   = 1'b0;
    rd_done   = 1'b0;
    case (state)
      IDLE: if (full[rd_bank]) state_nxt = READ;
      READ: begin
        if (!out_valid || out_ready) begin
          rd_load = 1'b1;
          if (rd_cnt == idx_t'(N-1)) begin
            rd_done   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      full      <= 2'b00;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
`ifdef FFT_REORDER_BYPASS_EN
      bypass_q  <= 1'b0;
`endif
    end else begin
      full <= (full | full_set) & ~full_clr;
      if (wr_accept) begin
        if (wr_last) begin
          wr_cnt  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_cnt  <= wr_addr + 1'b1;
        end
      end
      if (in_valid && full[wr_bank]) ovf <= 1'b1;
      if (state == IDLE && full[rd_bank]) begin
        rd_cnt   <= '0;
`ifdef FFT_REORDER_BYPASS_EN
        bypass_q <= bypass;
`endif
      end
      // The output register only advances when empty or being consumed, which keeps it stable under stall.
      if (rd_load) begin
        out_data  <= mem[{rd_bank, rd_addr}];
        out_valid <= 1'b1;
        out_last  <= (rd_cnt == idx_t'(N-1));
        rd_cnt    <= rd_cnt + 1'b1;
        if (rd_done) rd_bank <= ~rd_bank;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed self-checking bench for fft_bitrev_reorder with LOG2_N=3 (N=8).
// The bypass scenario is exercised only when FFT_REORDER_BYPASS_EN is defined.
module tb_fft_bitrev_reorder;
  localparam int DW = 32;
  localparam int LN = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          ovf;
`ifdef FFT_REORDER_BYPASS_EN
  logic          bypass = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  logic [DW-1:0] qd[$];
  logic          ql[$];
  int            qc[$];
  int            brev[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  fft_bitrev_reorder #(.DATA_WIDTH(DW), .LOG2_N(LN)) dut (
    .clk(clk),
    .rst(rst),
`ifdef FFT_REORDER_BYPASS_EN
    .bypass(bypass),
`endif
    .in_valid(in_valid),
    .in_sof(in_sof),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Record every handshake that the coming rising edge will complete.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      qd.push_back(out_data);
      ql.push_back(out_last);
      qc.push_back(cycle);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q;
    qd.delete();
    ql.delete();
    qc.delete();
  endtask

  task automatic do_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    in_sof = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    repeat (2) tick;
    rst = 1'b0;
    tick;
    clear_q;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic s);
    in_valid = 1'b1;
    in_data = d;
    in_sof = s;
    tick;
    in_valid = 1'b0;
    in_sof = 1'b0;
  endtask

  task automatic wait_outputs(input int n, input string name);
    int k;
    k = 0;
    while (qd.size() < n && k < 80) begin
      tick;
      k++;
    end
    checks++;
    if (qd.size() < n) begin
      errors++;
      $display("[TB] FAIL %s_timeout: got %0d outputs, expected %0d", name, qd.size(), n);
    end
  endtask

  task automatic test_reset;
    repeat (2) tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_last: got %b expected 0", out_last); end
    checks++; if (out_data !== '0) begin errors++; $display("[TB] FAIL reset_out_data: got %h expected 0", out_data); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_single_frame;
    logic [DW-1:0] got;
    clear_q;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(i, i == 0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL latency_edge0: out_valid got %b expected 0", out_valid); end
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL latency_edge1: out_valid got %b expected 0", out_valid); end
    tick;
    checks++; if (out_valid !== 1'b1 || out_data !== 0) begin errors++; $display("[TB] FAIL latency_edge2: out_valid/out_data got %b/%h expected 1/0", out_valid, out_data); end
    wait_outputs(8, "single");
    for (int i = 0; i < 8; i++) begin
      got = (i < qd.size()) ? qd[i] : 'x;
      checks++; if (got !== DW'(brev[i])) begin errors++; $display("[TB] FAIL single_data[%0d]: got %h expected %h", i, got, brev[i]); end
      checks++; if (i < ql.size() && ql[i] !== (i == 7)) begin errors++; $display("[TB] FAIL single_last[%0d]: got %b expected %b", i, ql[i], i == 7); end
    end
    repeat (4) tick;
    checks++; if (qd.size() != 8) begin errors++; $display("[TB] FAIL single_count: got %0d expected 8", qd.size()); end
  endtask

  // One idle input cycle between frames gives the reader time to free the bank the writer returns to.
  task automatic test_back_to_back;
    logic [DW-1:0] got;
    do_reset;
    out_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 8; i++) send(8*f + i, i == 0);
      tick;
    end
    wait_outputs(24, "b2b");
    for (int i = 0; i < 24; i++) begin
      got = (i < qd.size()) ? qd[i] : 'x;
      checks++; if (got !== DW'(8*(i/8) + brev[i%8])) begin errors++; $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", i, got, 8*(i/8) + brev[i%8]); end
      checks++; if (i < ql.size() && ql[i] !== (i%8 == 7)) begin errors++; $display("[TB] FAIL b2b_last[%0d]: got %b expected %b", i, ql[i], i%8 == 7); end
    end
    if (qc.size() >= 24) begin
      checks++; if (qc[8] - qc[7] != 2) begin errors++; $display("[TB] FAIL b2b_gap1: got %0d cycles expected 2", qc[8] - qc[7]); end
      checks++; if (qc[16] - qc[15] != 2) begin errors++; $display("[TB] FAIL b2b_gap2: got %0d cycles expected 2", qc[16] - qc[15]); end
    end
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ovf: got %b expected 0", ovf); end
  endtask

  task automatic test_stall;
    logic [DW-1:0] got;
    logic bad;
    do_reset;
    bad = 1'b0;
    for (int k = 0; k < 24; k++) begin
      send(k, k%8 == 0);
      if (k >= 10 && (out_valid !== 1'b1 || out_data !== 0)) bad = 1'b1;
    end
    repeat (2) tick;
    checks++; if (bad) begin errors++; $display("[TB] FAIL stall_hold: out_data/out_valid changed while stalled, now %h/%b expected 0/1", out_data, out_valid); end
    checks++; if (out_valid !== 1'b1 || out_data !== 0) begin errors++; $display("[TB] FAIL stall_head: got %b/%h expected 1/0", out_valid, out_data); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL stall_ovf: got %b expected 1", ovf); end
    out_ready = 1'b1;
    wait_outputs(16, "stall");
    repeat (6) tick;
    checks++; if (qd.size() != 16) begin errors++; $display("[TB] FAIL stall_count: got %0d expected 16", qd.size()); end
    for (int i = 0; i < 16; i++) begin
      got = (i < qd.size()) ? qd[i] : 'x;
      checks++; if (got !== DW'(8*(i/8) + brev[i%8])) begin errors++; $display("[TB] FAIL stall_data[%0d]: got %h expected %h", i, got, 8*(i/8) + brev[i%8]); end
    end
  endtask

  task automatic test_toggle_ready;
    logic [DW-1:0] got;
    logic [DW-1:0] hold_d;
    logic hold_v;
    logic hold_l;
    do_reset;
    for (int i = 0; i < 8; i++) send(32 + i, i == 0);
    for (int i = 0; i < 30; i++) begin
      out_ready = (i % 2 == 0);
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      hold_l = out_last;
      tick;
      if (hold_v) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== hold_d || out_last !== hold_l) begin
          errors++;
          $display("[TB] FAIL toggle_stable[%0d]: got %b/%h/%b expected 1/%h/%b", i, out_valid, out_data, out_last, hold_d, hold_l);
        end
      end
    end
    out_ready = 1'b1;
    wait_outputs(8, "toggle");
    repeat (4) tick;
    checks++; if (qd.size() != 8) begin errors++; $display("[TB] FAIL toggle_count: got %0d expected 8", qd.size()); end
    for (int i = 0; i < 8; i++) begin
      got = (i < qd.size()) ? qd[i] : 'x;
      checks++; if (got !== DW'(32 + brev[i])) begin errors++; $display("[TB] FAIL toggle_data[%0d]: got %h expected %h", i, got, 32 + brev[i]); end
    end
  endtask

  task automatic test_reset_mid_read;
    logic [DW-1:0] got;
    do_reset;
    for (int k = 0; k < 24; k++) send(100 + k, k%8 == 0);
    checks++; if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ovf_before: got %b expected 1", ovf); end
    out_ready = 1'b1;
    wait_outputs(3, "midrst");
    #2;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("[TB] FAIL midrst_out_last: got %b expected 0", out_last); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ovf: got %b expected 0", ovf); end
    tick;
    rst = 1'b0;
    tick;
    clear_q;
    for (int i = 0; i < 8; i++) send(i, i == 0);
    wait_outputs(8, "midrst_fresh");
    repeat (12) tick;
    checks++; if (qd.size() != 8) begin errors++; $display("[TB] FAIL midrst_count: got %0d expected 8", qd.size()); end
    for (int i = 0; i < 8; i++) begin
      got = (i < qd.size()) ? qd[i] : 'x;
      checks++; if (got !== DW'(brev[i])) begin errors++; $display("[TB] FAIL midrst_data[%0d]: got %h expected %h", i, got, brev[i]); end
    end
  endtask

  task automatic test_sof_realign;
    logic [DW-1:0] got;
    do_reset;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(50 + i, i == 0);
    send(60, 1'b1);
    for (int i = 1; i < 7; i++) send(60 + i, 1'b0);
    repeat (3) tick;
    checks++; if (qd.size() != 0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL sof_early: got %0d outputs valid=%b expected 0/0", qd.size(), out_valid); end
    send(67, 1'b0);
    wait_outputs(8, "sof");
    for (int i = 0; i < 8; i++) begin
      got = (i < qd.size()) ? qd[i] : 'x;
      checks++; if (got !== DW'(60 + brev[i])) begin errors++; $display("[TB] FAIL sof_data[%0d]: got %h expected %h", i, got, 60 + brev[i]); end
    end
  endtask

`ifdef FFT_REORDER_BYPASS_EN
  task automatic test_bypass;
    logic [DW-1:0] got;
    do_reset;
    bypass = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(i, i == 0);
    wait_outputs(8, "bypass");
    for (int i = 0; i < 8; i++) begin
      got = (i < qd.size()) ? qd[i] : 'x;
      checks++; if (got !== DW'(i)) begin errors++; $display("[TB] FAIL bypass_data[%0d]: got %h expected %h", i, got, i); end
    end
    bypass = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_single_frame;
    test_back_to_back;
    test_stall;
    test_toggle_ready;
    test_reset_mid_read;
    test_sof_realign;
`ifdef FFT_REORDER_BYPASS_EN
    test_bypass;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
